// File: rtl/input_debouncer.sv
// Debounces one asynchronous pin: synchroniser, stable-time qualifier FSM,
// registered clean level with rise/fall strobes and a saturating glitch counter.
module input_debouncer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 raw_in,
  input  logic                 sample_en,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic                 clr_glitch,
  output logic                 level,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [3:0]           glitch_cnt
);

  typedef enum logic [1:0] {LOW, L2H, HIGH, H2L} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, thr_m1;
  logic                   level_d, rise_d, fall_d, glitch_inc;
  logic [3:0]             glitch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // threshold 0 behaves as 1; compare against thr_eff-1 so a lowered
  // threshold mid-count qualifies on the next tick instead of overrunning.
  assign thr_m1 = (threshold == '0) ? '0 : threshold - CNT_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    case (state_q)
      LOW: if (s) begin
        state_d = L2H;
        cnt_d   = '0;
      end
      L2H: begin
        if (!s) begin
          state_d    = LOW;
          glitch_inc = 1'b1;
        end else if (sample_en) begin
          if (cnt_q >= thr_m1) begin
            state_d = HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      HIGH: if (!s) begin
        state_d = H2L;
        cnt_d   = '0;
      end
      H2L: begin
        if (s) begin
          state_d    = HIGH;
          glitch_inc = 1'b1;
        end else if (sample_en) begin
          if (cnt_q >= thr_m1) begin
            state_d = LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = LOW;
    endcase
  end

  always_comb begin
    glitch_d = glitch_cnt;
    if (clr_glitch)                            glitch_d = 4'd0;
    else if (glitch_inc && glitch_cnt != 4'hF) glitch_d = glitch_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOW;
      cnt_q      <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      glitch_cnt <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level      <= level_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      glitch_cnt <= glitch_d;
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (SYNC_STAGES=2, CNT_WIDTH=8).
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw_in = 1'b0;
  logic       sample_en = 1'b1;
  logic [7:0] threshold = 8'd4;
  logic       clr_glitch = 1'b0;
  logic       level, rise_pulse, fall_pulse;
  logic [3:0] glitch_cnt;

  int tests = 0;
  int fails = 0;
  int rises, falls;

  input_debouncer #(.SYNC_STAGES(2), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .sample_en(sample_en),
    .threshold(threshold), .clr_glitch(clr_glitch), .level(level),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // outs = {level, rise, fall, glitch_cnt}
  function automatic logic [6:0] outs();
    return {level, rise_pulse, fall_pulse, glitch_cnt};
  endfunction

  initial begin
    // reset state
    #2;
    check("reset_outs", 32'(outs()), 32'h0);
    tick(2);
    rst_n = 1'b1;

    // idle 50 cycles
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle", 32'(outs()), 32'h0);
    end

    // rise latency thr=4: level at edge 7
    raw_in = 1'b1;
    tick(6);
    check("rise_before", 32'(outs()), 32'h0);
    tick();
    check("rise_edge7", 32'(outs()), {25'd0, 3'b110, 4'd0});
    tick();
    check("rise_one_cycle", 32'(outs()), {25'd0, 3'b100, 4'd0});

    // fall latency
    raw_in = 1'b0;
    tick(6);
    check("fall_before", 32'(outs()), {25'd0, 3'b100, 4'd0});
    tick();
    check("fall_edge7", 32'(outs()), {25'd0, 3'b001, 4'd0});
    tick();
    check("fall_one_cycle", 32'(outs()), 32'h0);

    // four 2-cycle bounces then hold high
    rises = 0;
    for (int i = 0; i < 4; i++) begin
      raw_in = 1'b1; tick(); rises += rise_pulse; tick(); rises += rise_pulse;
      raw_in = 1'b0; tick(); rises += rise_pulse; tick(); rises += rise_pulse;
    end
    raw_in = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); rises += rise_pulse; end
    check("bounce_glitches", 32'(glitch_cnt), 32'd4);
    check("bounce_one_rise", 32'(rises), 32'd1);
    check("bounce_level", 32'(level), 32'd1);

    // low glitches in HIGH until saturation
    falls = 0;
    for (int i = 0; i < 12; i++) begin
      raw_in = 1'b0; tick(); falls += fall_pulse; tick(); falls += fall_pulse;
      raw_in = 1'b1; tick(); falls += fall_pulse; tick(); falls += fall_pulse;
      if (i == 10) begin
        tick(2);
        check("sat_reach15", 32'(glitch_cnt), 32'd15);
      end
    end
    tick(2);
    check("sat_hold15", 32'(glitch_cnt), 32'd15);
    check("sat_no_fall", 32'(falls), 32'd0);
    check("sat_level", 32'(level), 32'd1);

    // clear while a glitch is being counted
    clr_glitch = 1'b1;
    raw_in = 1'b0; tick(2);
    raw_in = 1'b1; tick(4);
    check("clr_priority", 32'(glitch_cnt), 32'd0);
    clr_glitch = 1'b0;
    tick(2);
    check("clr_stays0", 32'(glitch_cnt), 32'd0);

    // threshold 0 acts as 1: fall at edge 4
    threshold = 8'd0;
    raw_in = 1'b0;
    tick(3);
    check("thr0_before", 32'(outs()), {25'd0, 3'b100, 4'd0});
    tick();
    check("thr0_edge4", 32'(outs()), {25'd0, 3'b001, 4'd0});

    // threshold lowered 200 -> 2 at cnt=10 inside L2H
    tick(2);
    threshold = 8'd200;
    raw_in = 1'b1;
    tick(13);
    check("thr_low_before", 32'(level), 32'd0);
    threshold = 8'd2;
    tick();
    check("thr_low_rise", 32'({level, rise_pulse}), 32'b11);

    // back to LOW with threshold 1
    threshold = 8'd1;
    raw_in = 1'b0;
    tick(6);
    check("thr1_fall", 32'(level), 32'd0);

    // sample_en every 4th clk, threshold 3: qualify on edge 12
    threshold = 8'd3;
    raw_in = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      sample_en = ((e % 4) == 0);
      tick();
      check("sen_level", 32'({level, rise_pulse}),
            (e >= 12) ? ((e == 12) ? 32'b11 : 32'b10) : 32'b00);
    end
    sample_en = 1'b1;

    // back to LOW, add one glitch, then reset mid-L2H with cnt=3
    threshold = 8'd1;
    raw_in = 1'b0;
    tick(6);
    threshold = 8'd8;
    raw_in = 1'b1; tick(2);
    raw_in = 1'b0; tick(6);
    check("pre_rst_glitch", 32'(outs()), 32'd1);
    raw_in = 1'b1;
    tick(6);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", 32'(outs()), 32'h0);
    tick();
    rst_n = 1'b1;
    rises = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      rises += rise_pulse;
    end
    check("rst_restart_wait", 32'({level, rises[0]}), 32'b00);
    tick();
    check("rst_restart_rise", 32'(outs()), {25'd0, 3'b110, 4'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions one raw external stimulus pin (touch/button) before it reaches the edge-triggered stimulus counter.
- Synchronises the pin into clk, rejects bounce/glitches shorter than a programmable stable time, and presents a clean level plus one-cycle rise/fall strobes.
- Keeps a saturating count of rejected glitches for debug readout.
- The clean level output drives the downstream edge counter's trigger input.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on raw_in; legal values are 2 or more.
- CNT_WIDTH, 8, width of the stable-time counter and of the threshold input.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- raw_in  input  1  asynchronous raw stimulus pin
- sample_en  input  1  sampling tick; the stable counter advances only on cycles where this is high (tie high for per-clk counting)
- threshold  input  CNT_WIDTH  number of sample_en ticks raw must stay stable to be accepted; value 0 is treated as 1
- clr_glitch  input  1  synchronous clear of glitch_cnt
- level  output  1  debounced level
- rise_pulse  output  1  one-clk strobe on accepted 0->1 transition
- fall_pulse  output  1  one-clk strobe on accepted 1->0 transition
- glitch_cnt  output  4  saturating count of rejected transitions

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While rst_n is low:
  - all synchroniser flops = 0
  - state = LOW, cnt = 0
  - level = 0, rise_pulse = 0, fall_pulse = 0, glitch_cnt = 0
- Reset mid-operation aborts any pending transition immediately. No pulse is emitted on reset entry or exit.
- Synchroniser: s is the output of the SYNC_STAGES-deep chain. The FSM uses only s, never raw_in.
- FSM states: LOW, L2H, HIGH, H2L. All outputs are registered.
- LOW:
  - s=1 -> L2H, cnt<=0.
  - Otherwise hold.
- L2H:
  - s=0 -> LOW; glitch_cnt increments.
  - Else if sample_en and cnt >= thr_eff-1 -> HIGH; level<=1; rise_pulse<=1 for exactly one cycle.
  - Else if sample_en -> cnt<=cnt+1.
  - Else hold.
- HIGH:
  - s=0 -> H2L, cnt<=0.
  - Otherwise hold.
- H2L: mirror of L2H.
  - s=1 -> HIGH; glitch_cnt increments.
  - On qualification -> LOW; level<=0; fall_pulse<=1 for one cycle.
- thr_eff = max(threshold, 1).
- threshold is used live. The ">=" compare guarantees no counter overrun if threshold is lowered mid-count. Raising it mid-count extends the wait.
- cnt never wraps: it is bounded by thr_eff-1 ≤ 2^CNT_WIDTH-2 before it qualifies.
- Latency with sample_en=1 and threshold=N: level and the strobe assert SYNC_STAGES+N+1 clk edges after the first edge that samples raw_in changed.
- rise_pulse and fall_pulse are never high together and never high in consecutive cycles.
- glitch_cnt:
  - saturates at 15.
  - clr_glitch has priority over increment in the same cycle (result 0).
- A glitch shorter than the synchroniser resolution may never reach s. It is then neither counted nor propagated.
- sample_en low in LOW/HIGH has no effect. Direction changes are always checked every clk, regardless of sample_en.

Test Plan:
- Reset then idle, raw_in=0, threshold=4, sample_en=1 -> level=0, no strobes, glitch_cnt=0 for 50 cycles.
- raw_in steps 0->1 and holds, threshold=4, SYNC_STAGES=2 -> level rises after edge 7 from the sampling edge; rise_pulse high for exactly that one cycle. Then raw_in 1->0 -> fall_pulse after the same latency.
- raw_in bounces 1,0,1,0,1 with 2-cycle periods, then holds 1, threshold=4 -> glitch_cnt=4, single rise_pulse, level=1. Repeat until glitch_cnt saturates at 15 -> stays 15. Pulse clr_glitch together with a glitch -> 0.
- sample_en high every 4th clk, threshold=3, raw_in held 1 -> qualification after the 3rd sample_en tick inside L2H; level unchanged before that.
- threshold=0 -> behaves as 1. threshold lowered from 200 to 2 while cnt=10 in L2H -> transition on the next sample_en tick.
- rst_n asserted mid-L2H with cnt=3 -> all outputs 0 immediately. After release, raw_in still high -> full qualification restarts from cnt=0.
